pulse_shaper: RTL and testbench



---
 rtl/pulse_shaper.sv | 114 +++++++++++
 tb/tb_pulse_shaper.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pulse_shaper.sv
// Multi-channel pulse conditioner: optional input synchroniser followed by a
// per-channel shaper (pass, retriggerable extend, high-time limit, one-shot).
module pulse_shaper #(
  parameter int CHANNELS   = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int CNT_BITS   = 8,
  parameter int O_REG      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          i,
  input  logic [2*CHANNELS-1:0]        mode,
  input  logic [CNT_BITS*CHANNELS-1:0] len,
  output logic [CHANNELS-1:0]          o,
  output logic [CHANNELS-1:0]          busy
);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_EXTEND  = 2'b01,
    MODE_LIMIT   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic                w_s;
    logic                w_oc;
    logic                w_cntNz;
    logic [CNT_BITS-1:0] w_cntDec;
    logic [CNT_BITS-1:0] w_cntNext;
    logic [CNT_BITS-1:0] w_len;
    mode_e               w_mode;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_sPrev;
    mode_e               r_modeQ;

    assign w_mode   = mode_e'(mode[2*n +: 2]);
    assign w_len    = len[CNT_BITS*n +: CNT_BITS];
    assign w_cntNz  = (r_cnt != '0);
    assign w_cntDec = r_cnt - CNT_BITS'(1);

    // Synchroniser flops stay discrete and unreset so metastability settles per stage.
    if (SYNC_DEPTH == 0) begin : g_noSync
      assign w_s = i[n];
    end else begin : g_sync
      (* shreg_extract = "no", async_reg = "true" *) logic [SYNC_DEPTH-1:0] r_sync;
      if (SYNC_DEPTH == 1) begin : g_one
        always_ff @(posedge clk) r_sync <= i[n];
      end else begin : g_chain
        always_ff @(posedge clk) r_sync <= {r_sync[SYNC_DEPTH-2:0], i[n]};
      end
      assign w_s = r_sync[SYNC_DEPTH-1];
    end

    always_comb begin
      w_cntNext = '0;
      w_oc      = 1'b0;
      case (r_modeQ)
        MODE_PASS: begin
          w_oc = w_s;
        end
        MODE_EXTEND: begin
          w_oc = w_s | w_cntNz;
          if (w_s)          w_cntNext = w_len;
          else if (w_cntNz) w_cntNext = w_cntDec;
        end
        MODE_LIMIT: begin
          w_oc = w_s & w_cntNz;
          if (!w_s)         w_cntNext = w_len;
          else if (w_cntNz) w_cntNext = w_cntDec;
        end
        MODE_ONESHOT: begin
          w_oc = w_cntNz;
          if (w_s && !r_sPrev && !w_cntNz) w_cntNext = w_len;
          else if (w_cntNz)                w_cntNext = w_cntDec;
        end
        default: begin
          w_oc = 1'b0;
        end
      endcase
    end

    // s_prev resets high so an input already high at reset never counts as an edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_sPrev <= 1'b1;
        r_modeQ <= w_mode;
      end else begin
        r_sPrev <= w_s;
        if (w_mode != r_modeQ) begin
          r_cnt   <= '0;
          r_modeQ <= w_mode;
        end else begin
          r_cnt <= w_cntNext;
        end
      end
    end

    assign busy[n] = w_cntNz;

    if (O_REG != 0) begin : g_oReg
      logic r_o;
      always_ff @(posedge clk) begin
        if (rst) r_o <= 1'b0;
        else     r_o <= w_oc;
      end
      assign o[n] = r_o;
    end else begin : g_oComb
      assign o[n] = w_oc;
    end
  end

endmodule

// File: tb/tb_pulse_shaper.sv
// Bench for pulse_shaper: table-driven per-channel waveforms checked through a
// scoreboard queue, plus hand-written reset, mode-change and held-input sequences.
module tb_pulse_shaper;

  localparam int N = 24;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] len;
    logic [0:N-1] pin;
    logic [0:N-1] eo;
    logic [0:N-1] eb;
  } vec_t;

  typedef struct {
    logic [3:0] o;
    logic [3:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i;
  logic [7:0]  mode;
  logic [31:0] len;
  logic [3:0]  o;
  logic [3:0]  busy;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[12];
  exp_t sbq[$];

  pulse_shaper #(
    .CHANNELS(4), .SYNC_DEPTH(2), .CNT_BITS(8), .O_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .i(i), .mode(mode), .len(len), .o(o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] iv, input logic rv);
    @(negedge clk);
    i   = iv;
    rst = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Expected entries are aligned to the input cycle; each surfaces two edges later.
  task automatic runVectors(input int v0, input int v1, input int v2, input int v3);
    int         vs[4];
    exp_t       e;
    logic [3:0] iv;
    vs = '{v0, v1, v2, v3};
    for (int ch = 0; ch < 4; ch++) begin
      mode[2*ch +: 2] = vecs[vs[ch]].mode;
      len[8*ch +: 8]  = vecs[vs[ch]].len;
    end
    sbq.delete();
    repeat (4) applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < N + 2; c++) begin
      iv  = '0;
      e.o = '0;
      e.b = '0;
      if (c < N) begin
        for (int ch = 0; ch < 4; ch++) begin
          iv[ch]  = vecs[vs[ch]].pin[c];
          e.o[ch] = vecs[vs[ch]].eo[c];
          e.b[ch] = vecs[vs[ch]].eb[c];
        end
        sbq.push_back(e);
      end
      applyStimulus(iv, 1'b0);
      if (c >= 2) begin
        e = sbq.pop_front();
        checkOutput($sformatf("v%0d.%0d.%0d.%0d t=%0d o", v0, v1, v2, v3, c - 2), int'(o), int'(e.o));
        checkOutput($sformatf("v%0d.%0d.%0d.%0d t=%0d busy", v0, v1, v2, v3, c - 2), int'(busy), int'(e.b));
      end
    end
  endtask

  initial begin
    int cntO0, cntO1;
    bit found;

    rst = 1'b1; i = '0; mode = '0; len = '0;

    vecs[0]  = '{2'b00, 8'd0, 24'b0000_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000};
    vecs[1]  = '{2'b00, 8'd9, 24'b0111_0000_0000_0000_0000_0000, 24'b0111_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000};
    vecs[2]  = '{2'b01, 8'd5, 24'b0100_0000_0000_0000_0000_0000, 24'b0111_1110_0000_0000_0000_0000, 24'b0111_1100_0000_0000_0000_0000};
    vecs[3]  = '{2'b01, 8'd5, 24'b0100_1000_0000_0000_0000_0000, 24'b0111_1111_1100_0000_0000_0000, 24'b0111_1111_1000_0000_0000_0000};
    vecs[4]  = '{2'b10, 8'd4, 24'b0111_1111_1110_0000_0000_0000, 24'b0111_1000_0000_0000_0000_0000, 24'b1111_0000_0001_1111_1111_1111};
    vecs[5]  = '{2'b10, 8'd4, 24'b0110_0000_0000_0000_0000_0000, 24'b0110_0000_0000_0000_0000_0000, 24'b1111_1111_1111_1111_1111_1111};
    vecs[6]  = '{2'b10, 8'd0, 24'b0111_1100_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000};
    vecs[7]  = '{2'b11, 8'd3, 24'b0101_0000_0000_0000_0000_0000, 24'b0011_1000_0000_0000_0000_0000, 24'b0111_0000_0000_0000_0000_0000};
    vecs[8]  = '{2'b11, 8'd3, 24'b0100_0100_0000_0000_0000_0000, 24'b0011_1011_1000_0000_0000_0000, 24'b0111_0111_0000_0000_0000_0000};
    vecs[9]  = '{2'b11, 8'd3, 24'b0100_1000_0000_0000_0000_0000, 24'b0011_1000_0000_0000_0000_0000, 24'b0111_0000_0000_0000_0000_0000};
    vecs[10] = '{2'b01, 8'd0, 24'b0111_0000_0000_0000_0000_0000, 24'b0111_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000};
    vecs[11] = '{2'b11, 8'd0, 24'b0110_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000, 24'b0000_0000_0000_0000_0000_0000};

    // Each vector rotates across channels so every channel gets exercised alone.
    for (int k = 1; k < 12; k++) begin
      runVectors((k % 4 == 0) ? k : 0, (k % 4 == 1) ? k : 0,
                 (k % 4 == 2) ? k : 0, (k % 4 == 3) ? k : 0);
    end

    runVectors(3, 4, 1, 9);

    $display("[TB] reset during a long extend pulse");
    mode = 8'b00_00_00_01; len = 32'd200;
    repeat (4) applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    repeat (12) applyStimulus(4'b0000, 1'b0);
    checkOutput("extendMidO", int'(o[0]), 1);
    checkOutput("extendMidBusy", int'(busy[0]), 1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("resetTruncO", int'(o), 0);
    checkOutput("resetTruncBusy", int'(busy), 0);

    $display("[TB] inputs held high through reset");
    mode = 8'b00_00_11_10; len = {8'd0, 8'd0, 8'd3, 8'd4};
    repeat (4) applyStimulus(4'b0011, 1'b1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0011, 1'b0);
      checkOutput($sformatf("heldHigh t=%0d o", c), int'(o), 0);
      checkOutput($sformatf("heldHigh t=%0d busy", c), int'(busy), 0);
    end
    cntO0 = 0; cntO1 = 0;
    for (int c = 0; c < 17; c++) begin
      applyStimulus((c >= 3 && c < 11) ? 4'b0011 : 4'b0000, 1'b0);
      cntO0 += int'(o[0]);
      cntO1 += int'(o[1]);
    end
    checkOutput("limitAfterToggle highCycles", cntO0, 4);
    checkOutput("oneshotAfterToggle highCycles", cntO1, 3);

    $display("[TB] mode change extend to limit");
    mode = 8'b00_00_01_00; len = {8'd0, 8'd0, 8'd7, 8'd0};
    repeat (4) applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      applyStimulus(4'b0000, 1'b0);
      found = busy[1];
    end
    checkOutput("modeChg loadSeen", int'(found), 1);
    mode[3:2] = 2'b10;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("modeChg cntCleared", int'(busy[1]), 0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("modeChg limitLoads", int'(busy[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
